fsm_seq_ctrl: RTL
=================

# fsm_seq_ctrl

Run controller for the team's 2-bit control FSM (`simple_fsm`: `clk`, `rst`, serial `in`, `state[1:0]`). On a `start` request it resets the FSM, drives a loaded bit pattern into its `in` input one bit per clock, LSB first, and watches the returned state for a target value. It reports completion, whether the target was hit, the index of the bit that caused the first hit, and the final FSM state. It replaces hand-written stimulus sequences with a reusable, self-checking sequencer that sits between system control and the FSM instance.

## Interface
- `PAT_W`, default 8: pattern width, in bits. Minimum 2.
- `CNT_W`, default 4: width of the length and index fields. Must satisfy 2^CNT_W > PAT_W.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `pattern`  in  PAT_W  bits to drive, LSB first; captured when `start` is accepted.
- `len`  in  CNT_W  number of bits to drive; captured when `start` is accepted.
- `target`  in  2  FSM state value to detect; captured when `start` is accepted.
- `fsm_state`  in  2  current state returned by the driven FSM.
- `fsm_in`  out  1  serial bit to the FSM `in` input.
- `fsm_rst`  out  1  reset to the FSM.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `hit`  out  1  target was seen during the run.
- `hit_idx`  out  CNT_W  index of the bit whose effect first matched `target`.
- `last_state`  out  2  `fsm_state` captured in SETTLE.

## Operation
- States: IDLE, RESET, DRIVE, SETTLE, DONE.
- IDLE: when `start`=1, capture `pattern`, `target` and the effective length, clear `hit`/`hit_idx`, then go to RESET. A `start` outside IDLE is ignored.
- Effective length: `len` clamped to PAT_W. A `len` of 0 is legal.
- RESET: `fsm_rst`=1 for exactly this one cycle. Next state is DRIVE if the effective length ≥1, otherwise SETTLE.
- DRIVE, cycle k (k = 0..len-1): `fsm_in` = pattern[k], taken from a shift register with a k counter.
  - For k ≥ 1, compare `fsm_state` (the effect of bit k-1) with `target`.
  - On the first match, set `hit`=1 and `hit_idx`=k-1.
  - After k = len-1, go to SETTLE.
- SETTLE: `fsm_in`=0.
  - If len ≠ 0, compare `fsm_state` (the effect of bit len-1); on the first match, `hit_idx`=len-1.
  - Capture `last_state` = `fsm_state`. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `hit`, `hit_idx` and `last_state` hold their values until the next accepted `start`.
- No comparison is made in RESET or in DRIVE k=0; the FSM reset state never counts as a hit.
- Reset values:
  - state = IDLE.
  - `fsm_in`, `fsm_rst`, `busy`, `done`, `hit` = 0.
  - `hit_idx` = 0, `last_state` = 2'b00.
- `rst` asserted mid-run: return to IDLE immediately and apply all reset values. No `done` is produced. `fsm_rst` is not asserted by this event.

## Timing
- All outputs are registered.
- `start` sampled at edge E0 → RESET follows E0 → DRIVE k=0 follows E1 → SETTLE follows E(1+len) → DONE follows E(2+len).
- `done` is high during the cycle after E(2+len). With len=0, `done` follows E2.
- `busy` rises after E0 and falls after E(3+len).
- Minimum spacing between consecutive `start` acceptances: len+4 cycles. A `start` held high in the cycle `done` is asserted is not accepted; it is accepted at the IDLE cycle that follows.
- The driven FSM is required to update `state` on the edge after it samples `in`: one cycle of latency, which the comparison offsets above account for.

## Structure
- Package `fsm_seq_pkg` holds:
  - the state enum typedef (3 bits: IDLE=0, RESET=1, DRIVE=2, SETTLE=3, DONE=4);
  - `FSM_STATE_W`=2.
- Single module. The shift register, bit counter and comparator are inline; a sub-module is not warranted.

## Test plan
Bench FSM model: `state <= {state[0], in}`, reset value 00.
- Basic hit: pattern=8'b0000_0110, len=4, target=2'b11.
  - `fsm_in` sequence = 0,1,1,0.
  - Response: `hit`=1, `hit_idx`=2, `last_state`=2'b10, `done` after E6.
- Miss: pattern=8'b0101_0101, len=8, target=2'b11.
  - Response: `hit`=0, `last_state`=2'b10, `done` after E10.
- Hit on the last bit: pattern=8'b0000_0011, len=2, target=2'b11.
  - Response: `hit`=1, `hit_idx`=1, detected in SETTLE.
- Zero and over-length:
  - len=0 → `done` after E2, `hit`=0, no DRIVE cycles.
  - len=15 → clamped to 8: exactly 8 DRIVE cycles.
- `start` while busy: ignored, captured registers unchanged.
- Reset mid-run: assert `rst` during DRIVE k=3 → all outputs at reset values on the next cycle, no `done`; a fresh run after release completes normally.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types for the simple_fsm run sequencer.
// Holds the sequencer state encoding and the width of the driven FSM's state.
package fsm_seq_pkg;

  localparam int FSM_STATE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_DRIVE  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fsm_seq_ctrl.sv
// Run controller: resets simple_fsm, shifts a pattern into its serial input LSB first,
// and reports whether/when the returned state matched a target.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [CNT_W-1:0]       len,
  input  logic [FSM_STATE_W-1:0] target,
  input  logic [FSM_STATE_W-1:0] fsm_state,
  output logic                   fsm_in,
  output logic                   fsm_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic [CNT_W-1:0]       hit_idx,
  output logic [FSM_STATE_W-1:0] last_state
);

  seq_state_t             state_reg;
  logic [PAT_W-1:0]       pat_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       len_reg;
  logic [FSM_STATE_W-1:0] target_reg;
  logic [CNT_W-1:0]       eff_len;
  logic                   match;

  assign eff_len = (len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len;
  // Only the first match is recorded; later matches leave hit_idx alone.
  assign match   = (fsm_state == target_reg) && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      pat_reg    <= '0;
      cnt_reg    <= '0;
      len_reg    <= '0;
      target_reg <= '0;
      fsm_in     <= 1'b0;
      fsm_rst    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      last_state <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            pat_reg    <= pattern;
            len_reg    <= eff_len;
            target_reg <= target;
            hit        <= 1'b0;
            hit_idx    <= '0;
            fsm_rst    <= 1'b1;
            fsm_in     <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= S_RESET;
          end
        end
        S_RESET: begin
          fsm_rst <= 1'b0;
          cnt_reg <= '0;
          if (len_reg != '0) begin
            fsm_in    <= pat_reg[0];
            pat_reg   <= pat_reg >> 1;
            state_reg <= S_DRIVE;
          end else begin
            fsm_in    <= 1'b0;
            state_reg <= S_SETTLE;
          end
        end
        S_DRIVE: begin
          // fsm_state now reflects bit cnt_reg-1 (one cycle of FSM latency).
          if (cnt_reg != '0 && match) begin
            hit     <= 1'b1;
            hit_idx <= cnt_reg - CNT_W'(1);
          end
          if (cnt_reg == len_reg - CNT_W'(1)) begin
            fsm_in    <= 1'b0;
            state_reg <= S_SETTLE;
          end else begin
            fsm_in  <= pat_reg[0];
            pat_reg <= pat_reg >> 1;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (len_reg != '0 && match) begin
            hit     <= 1'b1;
            hit_idx <= len_reg - CNT_W'(1);
          end
          last_state <= fsm_state;
          done       <= 1'b1;
          state_reg  <= S_DONE;
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          fsm_in    <= 1'b0;
          fsm_rst   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
